// File: rtl/ps2_pkg.sv
// -----------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 keyboard receiver: deframer state encoding,
// frame geometry, default timeout and the odd-parity helper.
// -----------------------------------------------------------------------------
package ps2_pkg;

    // Deframer states; encodings are fixed so the state can be probed directly.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_e;

    localparam int PS2_DATA_BITS      = 8;
    localparam int PS2_TIMEOUT_CYCLES = 5000;

    // PS/2 uses odd parity: data bits plus parity bit hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [PS2_DATA_BITS-1:0] data,
                                           input logic                     par);
        return (^data ^ par) == 1'b1;
    endfunction

endpackage

// File: rtl/ps2_receiver_if.sv
// -----------------------------------------------------------------------------
// ps2_receiver_if
// CPU-side bus of the PS/2 receiver.
//   rdEn      CPU -> rx  pop request (ignored while valid=0)
//   dataOut   rx -> CPU  head-of-FIFO scancode, first-word fall-through
//   valid     rx -> CPU  FIFO non-empty
//   irq       rx -> CPU  valid delayed by one cycle
//   frameErr  rx -> CPU  one-cycle pulse per rejected frame
//   overflow  rx -> CPU  sticky byte-dropped flag
// The receiver uses the slave modport, the CPU side the master modport.
// -----------------------------------------------------------------------------
interface ps2_receiver_if;
    import ps2_pkg::*;

    logic                     rdEn;
    logic [PS2_DATA_BITS-1:0] dataOut;
    logic                     valid;
    logic                     irq;
    logic                     frameErr;
    logic                     overflow;

    modport master (
        output rdEn,
        input  dataOut, valid, irq, frameErr, overflow
    );

    modport slave (
        input  rdEn,
        output dataOut, valid, irq, frameErr, overflow
    );

endinterface

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock first-word fall-through FIFO with a sticky overflow flag.
//   clk, rst    clock, asynchronous active-high reset
//   i_push      write request; dropped (and overflow set) when full with no pop
//   i_pop       read request; ignored when empty
//   i_data      write data
//   o_data      head entry, forced to 0 while empty
//   o_full      count == DEPTH
//   o_empty     count == 0
//   o_overflow  sticky until reset
// DEPTH must be a power of two, at least 2, so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_overflow;

    logic w_do_pop;
    logic w_do_push;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);

    // A pop in the same cycle frees the slot, so a push into a full FIFO
    // still succeeds when accompanied by a pop.
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (i_push && !w_do_push) r_overflow <= 1'b1;
        end
    end

    // NOTE: the storage array has no reset; its contents are only observable
    // through o_data, which is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_data     = o_empty ? '0 : r_mem[r_rd_ptr];
    assign o_overflow = r_overflow;

endmodule

// File: rtl/ps2_receiver.sv
// -----------------------------------------------------------------------------
// ps2_receiver
// Keyboard-side front end of the PS/2 port. Synchronizes and deglitches the
// raw PS/2 lines, deframes 11-bit device-to-host frames (start, 8 data bits
// LSB first, odd parity, stop), and buffers good scancodes for the CPU.
//   clk         50 MHz system clock
//   rst         asynchronous active-high reset
//   ps2CLK      raw PS/2 clock line (asynchronous)
//   ps2DATA     raw PS/2 data line (asynchronous)
//   ps2Inhibit  request to hold the PS/2 clock low; the board top level acts
//               on its rising edge. High while the FIFO is full, plus a
//               one-cycle pulse for each parity/stop error.
//   bus         CPU-side interface (slave): rdEn, dataOut, valid, irq,
//               frameErr, overflow
// -----------------------------------------------------------------------------
module ps2_receiver
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ps2CLK,
    input  logic          ps2DATA,
    output logic          ps2Inhibit,
    ps2_receiver_if.slave bus
);

    localparam int FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int BCW = $clog2(PS2_DATA_BITS) + 1;
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

    // Input conditioning
    logic [1:0]     r_clk_sync;
    logic [1:0]     r_dat_sync;
    logic [FCW-1:0] r_filt_cnt;
    logic           r_clk_filt;
    logic           r_clk_filt_d;
    logic           w_fe;
    logic           w_bit;

    // Deframer
    ps2_state_e               r_state;
    ps2_state_e               w_state_nxt;
    logic [BCW-1:0]           r_bit_cnt;
    logic [PS2_DATA_BITS-1:0] r_shreg;
    logic                     r_par_ok;
    logic [TCW-1:0]           r_to_cnt;
    logic                     w_stop_ok;
    logic                     w_stop_err;
    logic                     w_timeout;

    // Output registers and FIFO status
    logic                     r_push;
    logic                     r_frame_err;
    logic                     r_inhibit;
    logic                     r_irq;
    logic                     w_full;
    logic                     w_empty;
    logic                     w_overflow;
    logic [PS2_DATA_BITS-1:0] w_fifo_data;

    // Both lines reset high, matching an idle bus, so releasing reset
    // cannot manufacture a falling edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clk_sync <= 2'b11;
            r_dat_sync <= 2'b11;
        end else begin
            r_clk_sync <= {r_clk_sync[0], ps2CLK};
            r_dat_sync <= {r_dat_sync[0], ps2DATA};
        end
    end

    // The filtered clock follows the synchronized clock only after
    // FILTER_LEN consecutive samples disagree with it; any agreeing sample
    // restarts the count, so short glitches never flip the level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_filt_cnt   <= '0;
            r_clk_filt   <= 1'b1;
            r_clk_filt_d <= 1'b1;
        end else begin
            r_clk_filt_d <= r_clk_filt;
            if (r_clk_sync[1] == r_clk_filt) begin
                r_filt_cnt <= '0;
            end else if (r_filt_cnt == FCW'(FILTER_LEN - 1)) begin
                r_filt_cnt <= '0;
                r_clk_filt <= r_clk_sync[1];
            end else begin
                r_filt_cnt <= r_filt_cnt + FCW'(1);
            end
        end
    end

    assign w_fe  = r_clk_filt_d & ~r_clk_filt;
    assign w_bit = r_dat_sync[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_stop_ok   = 1'b0;
        w_stop_err  = 1'b0;
        w_timeout   = 1'b0;
        if (w_fe) begin
            case (r_state)
                IDLE: begin
                    // A high bit while idle is just line noise, not an error.
                    if (!w_bit) w_state_nxt = DATA;
                end
                DATA: begin
                    if (r_bit_cnt == BCW'(PS2_DATA_BITS - 1)) w_state_nxt = PARITY;
                end
                PARITY: begin
                    w_state_nxt = STOP;
                end
                STOP: begin
                    w_state_nxt = IDLE;
                    if (w_bit && r_par_ok) w_stop_ok  = 1'b1;
                    else                   w_stop_err = 1'b1;
                end
                default: w_state_nxt = IDLE;
            endcase
        end else if (r_state != IDLE && r_to_cnt == TCW'(TIMEOUT_CYCLES)) begin
            w_timeout   = 1'b1;
            w_state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bit_cnt <= '0;
            r_shreg   <= '0;
            r_par_ok  <= 1'b0;
            r_to_cnt  <= '0;
        end else begin
            if (w_fe || r_state == IDLE) r_to_cnt <= '0;
            else                         r_to_cnt <= r_to_cnt + TCW'(1);

            if (w_timeout) begin
                r_bit_cnt <= '0;
                r_shreg   <= '0;
            end else if (w_fe) begin
                case (r_state)
                    IDLE: r_bit_cnt <= '0;
                    DATA: begin
                        // LSB arrives first, so shift in from the top.
                        r_shreg   <= {w_bit, r_shreg[PS2_DATA_BITS-1:1]};
                        r_bit_cnt <= r_bit_cnt + BCW'(1);
                    end
                    PARITY:  r_par_ok <= odd_parity_ok(r_shreg, w_bit);
                    default: ;
                endcase
            end
        end
    end

    // r_shreg holds the completed byte during the push cycle: only DATA
    // shifts it, and a new frame cannot reach DATA that soon.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_push      <= 1'b0;
            r_frame_err <= 1'b0;
            r_inhibit   <= 1'b0;
            r_irq       <= 1'b0;
        end else begin
            r_push      <= w_stop_ok;
            r_frame_err <= w_stop_err | w_timeout;
            r_inhibit   <= w_full | w_stop_err;
            r_irq       <= ~w_empty;
        end
    end

    sync_fifo #(
        .WIDTH (PS2_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (r_push),
        .i_pop      (bus.rdEn),
        .i_data     (r_shreg),
        .o_data     (w_fifo_data),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_overflow (w_overflow)
    );

    assign bus.dataOut  = w_fifo_data;
    assign bus.valid    = ~w_empty;
    assign bus.irq      = r_irq;
    assign bus.frameErr = r_frame_err;
    assign bus.overflow = w_overflow;
    assign ps2Inhibit   = r_inhibit;

endmodule

// File: tb/tb_ps2_receiver.sv
// -----------------------------------------------------------------------------
// tb_ps2_receiver
// Self-checking bench for ps2_receiver. A vector table covers single frames
// (good, bad parity, clock glitches); hand-written sequences cover FIFO
// overflow, frame timeout and reset in mid-frame. Expected scancodes go into
// a scoreboard queue as frames are driven and are popped as the CPU reads.
// PS/2 bits are shortened to 40 clk cycles to keep the run short.
// -----------------------------------------------------------------------------
module tb_ps2_receiver;
    import ps2_pkg::*;

    localparam int FIFO_DEPTH     = 8;
    localparam int FILTER_LEN     = 4;
    localparam int TIMEOUT_CYCLES = 5000;
    // Stop-bit clock fall to valid: 2 synchronizer flops, FILTER_LEN filter
    // samples, then push cycle and FIFO write.
    localparam int EXP_LAT        = 2 + FILTER_LEN + 2;

    logic clk;
    logic rst;
    logic ps2CLK;
    logic ps2DATA;
    logic ps2Inhibit;

    ps2_receiver_if bus ();

    ps2_receiver #(
        .FIFO_DEPTH     (FIFO_DEPTH),
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ps2CLK     (ps2CLK),
        .ps2DATA    (ps2DATA),
        .ps2Inhibit (ps2Inhibit),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] sb_q [$];

    // Cycle counter and output monitors
    int cyc = 0;
    always @(posedge clk) cyc++;

    int err_total      = 0;
    int last_err_cyc   = -1;
    int inh_rises      = 0;
    int inh_len        = 0;
    int last_inh_w     = 0;
    int valid_rise_cyc = -1;
    int irq_rise_cyc   = -1;
    logic inh_q = 1'b0, valid_q = 1'b0, irq_q = 1'b0;

    always @(negedge clk) begin
        if (bus.frameErr === 1'b1) begin
            err_total++;
            last_err_cyc = cyc;
        end
        if (ps2Inhibit && !inh_q) inh_rises++;
        if (ps2Inhibit) inh_len++;
        else begin
            if (inh_q) last_inh_w = inh_len;
            inh_len = 0;
        end
        if (bus.valid && !valid_q) valid_rise_cyc = cyc;
        if (bus.irq && !irq_q) irq_rise_cyc = cyc;
        inh_q   = ps2Inhibit;
        valid_q = bus.valid;
        irq_q   = bus.irq;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [10:0] frame_bits(input logic [7:0] d, input bit bad_par);
        return {1'b1, ~(^d) ^ bad_par, d, 1'b0};
    endfunction

    int last_fall_cyc = 0;

    // Each bit: data changes while the clock is high, 10 cycles high,
    // 20 low, 10 high. A glitch is a 2-cycle low pulse in the leading high.
    task automatic send_bits(input logic [10:0] bits, input int n, input bit glitch);
        for (int i = 0; i < n; i++) begin
            ps2DATA = bits[i];
            if (glitch) begin
                repeat (4) @(negedge clk);
                ps2CLK = 1'b0;
                repeat (2) @(negedge clk);
                ps2CLK = 1'b1;
                repeat (4) @(negedge clk);
            end else begin
                repeat (10) @(negedge clk);
            end
            ps2CLK = 1'b0;
            last_fall_cyc = cyc;
            repeat (20) @(negedge clk);
            ps2CLK = 1'b1;
            repeat (10) @(negedge clk);
        end
        ps2DATA = 1'b1;
    endtask

    task automatic pop_check(input string name);
        logic [7:0] exp;
        @(negedge clk);
        check({name, "_valid"}, 32'(bus.valid), 32'd1);
        if (sb_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_sb: scoreboard empty, dataOut 0x%0h", name, bus.dataOut);
        end else begin
            exp = sb_q.pop_front();
            check({name, "_data"}, 32'(bus.dataOut), 32'(exp));
        end
        bus.rdEn = 1'b1;
        @(negedge clk);
        bus.rdEn = 1'b0;
    endtask

    typedef struct {
        logic [7:0] data;
        bit         bad_par;
        bit         glitch;
        bit         exp_valid;
        int         exp_err;
        int         exp_inh;
    } vec_t;

    localparam int NV = 7;
    vec_t vecs [NV];

    initial begin
        int e0, i0, stop_cyc, tf, dt;

        vecs[0] = '{8'h1C, 1'b0, 1'b0, 1'b1, 0, 0};
        vecs[1] = '{8'h1C, 1'b1, 1'b0, 1'b0, 1, 1};
        vecs[2] = '{8'hF0, 1'b0, 1'b0, 1'b1, 0, 0};
        vecs[3] = '{8'h00, 1'b0, 1'b0, 1'b1, 0, 0};
        vecs[4] = '{8'hFF, 1'b0, 1'b0, 1'b1, 0, 0};
        vecs[5] = '{8'hA5, 1'b1, 1'b0, 1'b0, 1, 1};
        vecs[6] = '{8'h1C, 1'b0, 1'b1, 1'b1, 0, 0};

        rst      = 1'b1;
        ps2CLK   = 1'b1;
        ps2DATA  = 1'b1;
        bus.rdEn = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid",    32'(bus.valid),    32'd0);
        check("rst_irq",      32'(bus.irq),      32'd0);
        check("rst_inhibit",  32'(ps2Inhibit),   32'd0);
        check("rst_frameerr", 32'(bus.frameErr), 32'd0);
        check("rst_overflow", 32'(bus.overflow), 32'd0);
        check("rst_dataout",  32'(bus.dataOut),  32'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // Single frames from the table
        for (int i = 0; i < NV; i++) begin
            e0 = err_total;
            i0 = inh_rises;
            send_bits(frame_bits(vecs[i].data, vecs[i].bad_par), 11, vecs[i].glitch);
            stop_cyc = last_fall_cyc;
            if (vecs[i].exp_valid) sb_q.push_back(vecs[i].data);
            repeat (20) @(negedge clk);
            check($sformatf("v%0d_valid", i), 32'(bus.valid), 32'(vecs[i].exp_valid));
            check($sformatf("v%0d_errs", i), err_total - e0, vecs[i].exp_err);
            check($sformatf("v%0d_inh_pulses", i), inh_rises - i0, vecs[i].exp_inh);
            if (vecs[i].exp_valid) begin
                check($sformatf("v%0d_latency", i), valid_rise_cyc - stop_cyc, EXP_LAT);
                check($sformatf("v%0d_irq_lag", i), irq_rise_cyc - valid_rise_cyc, 1);
                pop_check($sformatf("v%0d_pop", i));
            end else begin
                check($sformatf("v%0d_inh_width", i), last_inh_w, 1);
            end
        end

        // Fill the FIFO, overflow it, then drain in order
        for (int b = 1; b <= FIFO_DEPTH + 1; b++) begin
            send_bits(frame_bits(8'(b), 1'b0), 11, 1'b0);
            if (b <= FIFO_DEPTH) sb_q.push_back(8'(b));
            if (b == FIFO_DEPTH) begin
                repeat (10) @(negedge clk);
                check("full_inhibit", 32'(ps2Inhibit), 32'd1);
                check("full_no_ovf",  32'(bus.overflow), 32'd0);
            end
        end
        repeat (10) @(negedge clk);
        check("ovf_set",          32'(bus.overflow), 32'd1);
        check("ovf_inhibit_held", 32'(ps2Inhibit),   32'd1);
        pop_check("ovf_pop0");
        repeat (3) @(negedge clk);
        check("ovf_inhibit_drop", 32'(ps2Inhibit), 32'd0);
        for (int k = 1; k < FIFO_DEPTH; k++) pop_check($sformatf("ovf_pop%0d", k));
        repeat (3) @(negedge clk);
        check("ovf_drained",      32'(bus.valid),    32'd0);
        check("ovf_sticky",       32'(bus.overflow), 32'd1);

        // Partial frame then a silent bus: timeout back to IDLE
        e0 = err_total;
        i0 = inh_rises;
        send_bits(frame_bits(8'h6E, 1'b0), 4, 1'b0);
        tf = last_fall_cyc;
        for (int w = 0; w < TIMEOUT_CYCLES + 1000 && err_total == e0; w++) @(negedge clk);
        check("to_err_pulse", err_total - e0, 1);
        dt = last_err_cyc - tf;
        check("to_delay_in_window",
              32'(dt >= TIMEOUT_CYCLES && dt <= TIMEOUT_CYCLES + 16), 32'd1);
        repeat (5) @(negedge clk);
        check("to_state_idle", 32'(dut.r_state), 32'(IDLE));
        check("to_no_inhibit", inh_rises - i0, 0);
        check("to_no_data",    32'(bus.valid), 32'd0);
        e0 = err_total;
        send_bits(frame_bits(8'hF0, 1'b0), 11, 1'b0);
        sb_q.push_back(8'hF0);
        repeat (20) @(negedge clk);
        check("to_next_errs", err_total - e0, 0);
        pop_check("to_next_pop");

        // Reset in the middle of a frame with two bytes buffered
        send_bits(frame_bits(8'h11, 1'b0), 11, 1'b0);
        sb_q.push_back(8'h11);
        send_bits(frame_bits(8'h22, 1'b0), 11, 1'b0);
        sb_q.push_back(8'h22);
        send_bits(frame_bits(8'h33, 1'b0), 6, 1'b0);
        #3 rst = 1'b1;
        #1;
        check("mid_rst_valid",    32'(bus.valid),            32'd0);
        check("mid_rst_count",    32'(dut.u_fifo.r_count),   32'd0);
        check("mid_rst_overflow", 32'(bus.overflow),         32'd0);
        check("mid_rst_irq",      32'(bus.irq),              32'd0);
        sb_q.delete();
        e0 = err_total;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("mid_rst_no_err", err_total - e0, 0);
        send_bits(frame_bits(8'h5A, 1'b0), 11, 1'b0);
        sb_q.push_back(8'h5A);
        repeat (20) @(negedge clk);
        check("post_rst_errs", err_total - e0, 0);
        pop_check("post_rst_pop");
        repeat (3) @(negedge clk);
        check("end_empty", 32'(bus.valid), 32'd0);
        check("end_sb_empty", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
